// File: rtl/set_host_pkg.sv
// Shared types for the set_host initiator: FSM state encoding, queued job record
// and job mode codes understood by the circle-set counting engine.
package set_host_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESULT
    } state_t;

    typedef struct packed {
        logic [23:0] central;
        logic [11:0] radius;
        logic [1:0]  mode;
    } job_t;

    localparam logic [1:0] MODE_A   = 2'd0;
    localparam logic [1:0] MODE_AND = 2'd1;
    localparam logic [1:0] MODE_XOR = 2'd2;
    localparam logic [1:0] MODE_BAD = 2'd3;

endpackage

// File: rtl/set_host_fifo.sv
// Synchronous job queue for set_host; registered head, no write-to-read bypass.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module set_host_fifo
    import set_host_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  job_t wdata,
    output job_t rdata,
    output logic full,
    output logic empty
);

    localparam int PW = $clog2(DEPTH);

    job_t          mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // A simultaneous push and pop leaves the occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/set_host.sv
// Initiator-side controller: queues jobs, starts the engine one job at a time and
// hands each result downstream. Define SET_HOST_TIMEOUT_EN to add the S_WAIT watchdog.
module set_host
    import set_host_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [23:0] job_central,
    input  logic [11:0] job_radius,
    input  logic [1:0]  job_mode,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_candidate,
    output logic        res_error,
    output logic        eng_en,
    output logic [23:0] eng_central,
    output logic [11:0] eng_radius,
    output logic [1:0]  eng_mode,
    input  logic        eng_busy,
    input  logic        eng_valid,
    input  logic [7:0]  eng_candidate,
    output logic        host_idle
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("set_host: FIFO_DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("set_host: TIMEOUT_CYCLES must be at least 1");
    end

    state_t state;
    state_t state_next;
    job_t   in_job;
    job_t   head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   pop;
    logic   timed_out;
    logic   unused_busy;

    assign in_job      = '{central: job_central, radius: job_radius, mode: job_mode};
    assign unused_busy = eng_busy;

    set_host_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (job_valid),
        .pop   (pop),
        .wdata (in_job),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef SET_HOST_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_count;

    // Cleared while issuing so it counts S_WAIT cycles from zero.
    always_ff @(posedge clk) begin
        if (rst || state == S_ISSUE) begin
            wait_count <= '0;
        end else if (state == S_WAIT) begin
            wait_count <= wait_count + 1'b1;
        end
    end

    assign timed_out = (state == S_WAIT) && (wait_count == WAIT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_next = (head.mode == MODE_BAD) ? S_RESULT : S_ISSUE;
                end
            end
            S_ISSUE:  state_next = S_WAIT;
            S_WAIT: begin
                if (eng_valid || timed_out) begin
                    state_next = S_RESULT;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_next = S_IDLE;
                end
            end
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        pop       = (state == S_IDLE) && !fifo_empty;
        eng_en    = (state == S_ISSUE);
        res_valid = (state == S_RESULT);
        host_idle = (state == S_IDLE) && fifo_empty;
        job_ready = !fifo_full;
    end

    // Engine fields move only on the pop; result registers load on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            eng_central   <= '0;
            eng_radius    <= '0;
            eng_mode      <= '0;
            res_candidate <= '0;
            res_error     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        eng_central <= head.central;
                        eng_radius  <= head.radius;
                        eng_mode    <= head.mode;
                        if (head.mode == MODE_BAD) begin
                            res_candidate <= '0;
                            res_error     <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (eng_valid) begin
                        res_candidate <= eng_candidate;
                        res_error     <= 1'b0;
                    end else if (timed_out) begin
                        res_candidate <= '0;
                        res_error     <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_set_host.sv
// Self-checking bench for set_host with a behavioural engine model.
// The watchdog section runs only when SET_HOST_TIMEOUT_EN is defined.
module tb_set_host;
    import set_host_pkg::*;

    typedef struct {
        logic [23:0] central;
        logic [11:0] radius;
        logic [1:0]  mode;
        logic [7:0]  expCand;
        logic        expErr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [23:0] job_central = '0;
    logic [11:0] job_radius = '0;
    logic [1:0]  job_mode = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [7:0]  res_candidate;
    logic        res_error;
    logic        eng_en;
    logic [23:0] eng_central;
    logic [11:0] eng_radius;
    logic [1:0]  eng_mode;
    logic        eng_busy;
    logic        eng_valid;
    logic [7:0]  eng_candidate;
    logic        host_idle;

    int checks = 0;
    int failures = 0;

    int          engDelay = 4;
    bit          engRespond = 1'b1;
    logic [7:0]  engXor = '0;
    int          engCnt = 0;
    logic        engValidModel = 1'b0;
    logic        engBusyModel = 1'b0;
    logic [7:0]  engCandModel = '0;
    logic        strayValid = 1'b0;
    logic [23:0] capCentral = '0;
    logic [11:0] capRadius = '0;
    logic [1:0]  capMode = '0;
    int          enCount = 0;
    int          fieldBreaks = 0;

    logic [7:0] gotCand[$];
    logic       gotErr[$];

    assign eng_valid     = engValidModel | strayValid;
    assign eng_busy      = engBusyModel;
    assign eng_candidate = engCandModel;

    always #5 clk = ~clk;

    set_host #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .job_valid     (job_valid),
        .job_ready     (job_ready),
        .job_central   (job_central),
        .job_radius    (job_radius),
        .job_mode      (job_mode),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_candidate (res_candidate),
        .res_error     (res_error),
        .eng_en        (eng_en),
        .eng_central   (eng_central),
        .eng_radius    (eng_radius),
        .eng_mode      (eng_mode),
        .eng_busy      (eng_busy),
        .eng_valid     (eng_valid),
        .eng_candidate (eng_candidate),
        .host_idle     (host_idle)
    );

    // Engine stand-in: answers engDelay cycles after eng_en with central[7:0]^engXor.
    always @(posedge clk) begin
        if (rst) begin
            engCnt        <= 0;
            engValidModel <= 1'b0;
            engBusyModel  <= 1'b0;
        end else begin
            engValidModel <= 1'b0;
            if (eng_en) begin
                engCnt       <= engDelay;
                engBusyModel <= 1'b1;
                capCentral   <= eng_central;
                capRadius    <= eng_radius;
                capMode      <= eng_mode;
                enCount      <= enCount + 1;
            end else if (engCnt != 0) begin
                if (eng_central !== capCentral || eng_radius !== capRadius || eng_mode !== capMode) begin
                    fieldBreaks <= fieldBreaks + 1;
                end
                if (engCnt == 1) begin
                    engBusyModel <= 1'b0;
                    if (engRespond) begin
                        engValidModel <= 1'b1;
                        engCandModel  <= capCentral[7:0] ^ engXor;
                    end
                end
                engCnt <= engCnt - 1;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_watchdog simulation did not finish, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge after the job was taken.
    task automatic applyStimulus(input vec_t v);
        int guard = 0;
        job_valid   = 1'b1;
        job_central = v.central;
        job_radius  = v.radius;
        job_mode    = v.mode;
        while (!job_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("push_accepted", 32'(job_ready), 32'd1);
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic waitResValid(input int budget, output int cycles);
        cycles = 0;
        while (!res_valid && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // Accepts n results, also finishing any push still pending on job_valid.
    task automatic collectResults(input int n, input int budget);
        int  cycles = 0;
        bit  pushNow;
        gotCand.delete();
        gotErr.delete();
        res_ready = 1'b1;
        while (gotCand.size() < n && cycles < budget) begin
            pushNow = job_valid && job_ready;
            if (res_valid) begin
                gotCand.push_back(res_candidate);
                gotErr.push_back(res_error);
            end
            @(negedge clk);
            if (pushNow) job_valid = 1'b0;
            cycles++;
        end
        checkOutput("collect_count", 32'(gotCand.size()), 32'(n));
    endtask

    function automatic logic [7:0] candAt(input int i);
        return (i < gotCand.size()) ? gotCand[i] : 8'hxx;
    endfunction

    function automatic logic errAt(input int i);
        return (i < gotErr.size()) ? gotErr[i] : 1'bx;
    endfunction

    vec_t vecs[6];
    vec_t one;

    initial begin
        int lat;
        int en0;
        int fb0;
        int bad;

        vecs[0] = '{24'h123456, 12'h210, MODE_A,   8'h56, 1'b0};
        vecs[1] = '{24'hABCDEF, 12'h330, MODE_AND, 8'hEF, 1'b0};
        vecs[2] = '{24'h000011, 12'h120, MODE_XOR, 8'h11, 1'b0};
        vecs[3] = '{24'h777777, 12'h440, MODE_BAD, 8'h00, 1'b1};
        vecs[4] = '{24'h0000A5, 12'h550, MODE_A,   8'hA5, 1'b0};
        vecs[5] = '{24'h00003C, 12'h660, MODE_XOR, 8'h3C, 1'b0};

        repeat (3) @(negedge clk);
        checkOutput("rst_eng_en", 32'(eng_en), 32'd0);
        checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_res_cand", 32'(res_candidate), 32'd0);
        checkOutput("rst_res_err", 32'(res_error), 32'd0);
        checkOutput("rst_eng_central", 32'(eng_central), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_job_ready", 32'(job_ready), 32'd1);
        checkOutput("rst_host_idle", 32'(host_idle), 32'd1);

        $display("[TB] single job, mode 0");
        engDelay = 130; engXor = 8'd29; res_ready = 1'b1;
        en0 = enCount; fb0 = fieldBreaks;
        one = '{24'h440000, 12'h300, MODE_A, 8'd29, 1'b0};
        applyStimulus(one);
        checkOutput("t1_no_early_en", 32'(eng_en), 32'd0);
        checkOutput("t1_busy_not_idle", 32'(host_idle), 32'd0);
        @(negedge clk);
        checkOutput("t1_eng_en", 32'(eng_en), 32'd1);
        checkOutput("t1_eng_central", 32'(eng_central), 32'h440000);
        checkOutput("t1_eng_radius", 32'(eng_radius), 32'h300);
        checkOutput("t1_eng_mode", 32'(eng_mode), 32'd0);
        waitResValid(400, lat);
        checkOutput("t1_latency", 32'(lat), 32'd132);
        checkOutput("t1_cand", 32'(res_candidate), 32'd29);
        checkOutput("t1_err", 32'(res_error), 32'd0);
        checkOutput("t1_en_count", 32'(enCount - en0), 32'd1);
        checkOutput("t1_fields_stable", 32'(fieldBreaks - fb0), 32'd0);
        @(negedge clk);
        checkOutput("t1_idle_after", 32'(host_idle), 32'd1);
        checkOutput("t1_res_dropped", 32'(res_valid), 32'd0);

        $display("[TB] illegal mode");
        engDelay = 4; engXor = '0; res_ready = 1'b0;
        en0 = enCount;
        one = '{24'h555555, 12'h110, MODE_BAD, 8'h00, 1'b1};
        applyStimulus(one);
        @(negedge clk);
        checkOutput("bad_res_valid", 32'(res_valid), 32'd1);
        checkOutput("bad_cand", 32'(res_candidate), 32'd0);
        checkOutput("bad_err", 32'(res_error), 32'd1);
        checkOutput("bad_eng_en", 32'(eng_en), 32'd0);
        res_ready = 1'b1;
        @(negedge clk);
        one = '{24'h000007, 12'h220, MODE_XOR, 8'h07, 1'b0};
        applyStimulus(one);
        collectResults(1, 100);
        checkOutput("bad_next_cand", 32'(candAt(0)), 32'h07);
        checkOutput("bad_next_err", 32'(errAt(0)), 32'd0);
        checkOutput("bad_en_count", 32'(enCount - en0), 32'd1);

        $display("[TB] backpressure");
        res_ready = 1'b0; engDelay = 5;
        one = '{24'h000042, 12'h310, MODE_AND, 8'h42, 1'b0};
        applyStimulus(one);
        one = '{24'h000099, 12'h320, MODE_XOR, 8'h99, 1'b0};
        applyStimulus(one);
        waitResValid(100, lat);
        en0 = enCount;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_candidate !== 8'h42 || res_error !== 1'b0) bad++;
        end
        checkOutput("bp_stable", 32'(bad), 32'd0);
        checkOutput("bp_cand", 32'(res_candidate), 32'h42);
        checkOutput("bp_no_issue", 32'(enCount - en0), 32'd0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checkOutput("bp_no_en_at_pop", 32'(eng_en), 32'd0);
        @(negedge clk);
        checkOutput("bp_en_after_accept", 32'(eng_en), 32'd1);
        collectResults(1, 100);
        checkOutput("bp_second_cand", 32'(candAt(0)), 32'h99);

        $display("[TB] queue full and ordering");
        @(negedge clk);
        res_ready = 1'b0; engDelay = 10;
        en0 = enCount; fb0 = fieldBreaks;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("q_ready_%0d", i), 32'(job_ready), 32'd1);
            job_valid   = 1'b1;
            job_central = vecs[i].central;
            job_radius  = vecs[i].radius;
            job_mode    = vecs[i].mode;
            @(negedge clk);
        end
        job_central = vecs[5].central;
        job_radius  = vecs[5].radius;
        job_mode    = vecs[5].mode;
        checkOutput("q_full_ready", 32'(job_ready), 32'd0);
        bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (job_ready !== 1'b0) bad++;
        end
        checkOutput("q_stalled", 32'(bad), 32'd0);
        collectResults(6, 2000);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("q_cand_%0d", i), 32'(candAt(i)), 32'(vecs[i].expCand));
            checkOutput($sformatf("q_err_%0d", i), 32'(errAt(i)), 32'(vecs[i].expErr));
        end
        checkOutput("q_en_count", 32'(enCount - en0), 32'd5);
        checkOutput("q_fields_stable", 32'(fieldBreaks - fb0), 32'd0);

        $display("[TB] stray engine strobe");
        repeat (2) @(negedge clk);
        strayValid = 1'b1;
        @(negedge clk);
        strayValid = 1'b0;
        @(negedge clk);
        checkOutput("stray_res_valid", 32'(res_valid), 32'd0);
        checkOutput("stray_idle", 32'(host_idle), 32'd1);

        $display("[TB] reset mid-job");
        engDelay = 1000; res_ready = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(vecs[i]);
        repeat (3) @(negedge clk);
        checkOutput("mid_busy", 32'(host_idle), 32'd0);
        en0 = enCount;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_eng_en", 32'(eng_en), 32'd0);
        checkOutput("mid_res_valid", 32'(res_valid), 32'd0);
        checkOutput("mid_job_ready", 32'(job_ready), 32'd1);
        checkOutput("mid_host_idle", 32'(host_idle), 32'd1);
        checkOutput("mid_eng_central", 32'(eng_central), 32'd0);
        repeat (10) @(negedge clk);
        checkOutput("mid_discarded", 32'(enCount - en0), 32'd0);
        checkOutput("mid_still_idle", 32'(host_idle), 32'd1);

`ifdef SET_HOST_TIMEOUT_EN
        $display("[TB] watchdog timeout");
        engRespond = 1'b0; engDelay = 3; res_ready = 1'b0;
        one = '{24'h000066, 12'h770, MODE_A, 8'h00, 1'b1};
        applyStimulus(one);
        waitResValid(100, lat);
        checkOutput("to_latency", 32'(lat), 32'd18);
        checkOutput("to_cand", 32'(res_candidate), 32'd0);
        checkOutput("to_err", 32'(res_error), 32'd1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        strayValid = 1'b1;
        @(negedge clk);
        strayValid = 1'b0;
        @(negedge clk);
        checkOutput("to_late_valid", 32'(res_valid), 32'd0);
        checkOutput("to_idle", 32'(host_idle), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
